sync_fifo_flags: RTL and testbench
==================================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 16: entry count, power of two, >=2.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2: almost_full asserts when count >= AFULL_TH.
REQ-004 SHALL have parameter AEMPTY_TH, default 2: almost_empty asserts when count <= AEMPTY_TH.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port w_en  input  1  write request.
REQ-008 SHALL have port din  input  WIDTH  write data.
REQ-009 SHALL have port r_en  input  1  read request.
REQ-010 SHALL have port dout  output  WIDTH  read data.
REQ-011 SHALL have port valid  output  1  dout holds a newly read word.
REQ-012 SHALL have port full / empty  output  1 each  occupancy == DEPTH / == 0.
REQ-013 SHALL have port almost_full / almost_empty  output  1 each  threshold flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow / underflow  output  1 each  one-cycle pulse on rejected write / read.

Function
REQ-016 SHALL use all DEPTH entries; read/write pointers are $clog2(DEPTH)+1 bits wide, with the MSB as wrap bit; full = addresses equal and wrap bits differ.
REQ-017 SHALL accept a write iff w_en && !full (registered full); the accepted write stores din at w_ptr, and w_ptr increments modulo 2*DEPTH.
REQ-018 SHALL accept a read iff r_en && !empty (registered empty); r_ptr increments modulo 2*DEPTH.
REQ-019 SHALL reject a write when full even if a read is accepted the same cycle; count then decrements by 1.
REQ-020 SHALL reject a read when empty even if a write is accepted the same cycle; count then increments by 1.
REQ-021 SHALL leave count unchanged when a write and a read are both accepted in the same cycle, with both pointers advancing.
REQ-022 SHALL update count, full, empty, almost_full and almost_empty in the cycle after the accepted operation; all of these are registered or derived from registered state only.
REQ-023 SHALL pulse overflow high for exactly one cycle, the cycle after w_en && full; underflow likewise for r_en && empty.
REQ-024 SHALL make pointer wrap-around invisible: data order is strictly FIFO across any number of wraps.

Reset
REQ-025 SHALL, when reset_n is low at a clock edge: set pointers and count to 0, dout to 0, and valid, overflow, underflow, full, almost_full to 0; set empty to 1; set almost_empty to 1 (0 <= AEMPTY_TH).
REQ-026 SHALL ignore w_en and r_en in any cycle where reset_n is low; reset mid-operation discards all stored data.
REQ-027 SHALL NOT reset memory contents.

Configuration
REQ-028 SHALL, with macro SYNC_FIFO_FWFT_EN undefined (standard mode): register dout <= mem[r_ptr] on an accepted read; dout valid one cycle later with valid high for exactly that cycle; dout holds otherwise.
REQ-029 SHALL, with SYNC_FIFO_FWFT_EN defined (first-word-fall-through): drive dout = mem[r_ptr] whenever !empty, with valid = !empty; an accepted read pops the head, and the next word appears on the following cycle; a word written into an empty FIFO appears on dout one cycle after the write; dout value is don't-care while empty.
REQ-030 SHALL keep all flag, count, overflow and underflow behaviour identical in both modes.

Verification (DEPTH=4, WIDTH=8, AFULL_TH=3, AEMPTY_TH=1)
REQ-031 SHALL cover: reset_n=0 for 2 cycles -> count=0, empty=1, almost_empty=1, full=0, dout=0x00, valid=0.
REQ-032 SHALL cover: write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_full=1 at count=3; full=1 at count=4; then a 5th write of 0x55 -> overflow pulses 1 cycle, count stays 4.
REQ-033 SHALL cover: 4 reads after REQ-032 -> standard mode: dout 0x11,0x22,0x33,0x44, each one cycle after its r_en with valid; FWFT mode: dout=0x11 before the first read; then a 5th read -> underflow pulse, empty=1.
REQ-034 SHALL cover: 10 cycles of simultaneous write/read at count=2 with incrementing data 0xA0.. -> count holds 2, pointers wrap twice, reads return 0xA0.. in order after the two pre-loaded words.
REQ-035 SHALL cover: at full, w_en=1 and r_en=1 with din=0x99 -> read accepted, write rejected, overflow=1, count 4->3; at empty, both asserted -> write accepted, underflow=1, count 0->1.
REQ-036 SHALL cover: reset_n=0 asserted at count=3 -> next cycle count=0, empty=1; a subsequent write of 0x5A and read return 0x5A.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: synchronous FIFO with registered occupancy flags; define SYNC_FIFO_FWFT_EN for first-word-fall-through output
module sync_fifo_flags #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     w_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     r_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AF = (AW+1)'(AFULL_TH);
   localparam logic [AW:0] AE = (AW+1)'(AEMPTY_TH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] w_ptr, r_ptr;
   logic wr_ok, rd_ok;
   assign full         = (w_ptr ^ r_ptr) == {1'b1, {AW{1'b0}}};
   assign empty        = w_ptr == r_ptr;
   assign almost_full  = count >= AF;
   assign almost_empty = count <= AE;
   assign wr_ok        = w_en && !full;
   assign rd_ok        = r_en && !empty;
   // pointers, occupancy and rejected-request pulses
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) w_ptr <= w_ptr + 1'b1;
         if (rd_ok) r_ptr <= r_ptr + 1'b1;
         if (wr_ok != rd_ok) count <= wr_ok ? count + 1'b1 : count - 1'b1;
         overflow  <= w_en && full;
         underflow <= r_en && empty;
      end
   end
   // storage is never cleared; writes are blocked while in reset
   always_ff @(posedge clk) begin
      if (reset_n && wr_ok) mem[w_ptr[AW-1:0]] <= din;
   end
`ifdef SYNC_FIFO_FWFT_EN
   // head of the queue is always presented while non-empty
   always_comb begin
      dout  = mem[r_ptr[AW-1:0]];
      valid = !empty;
   end
`else
   // registered read port: word appears the cycle after an accepted read
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dout  <= '0;
         valid <= 1'b0;
      end else begin
         valid <= rd_ok;
         if (rd_ok) dout <= mem[r_ptr[AW-1:0]];
      end
   end
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed self-checking bench for sync_fifo_flags (DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
module tb_sync_fifo_flags;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       w_en = 1'b0;
   logic       r_en = 1'b0;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic       valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [2:0] count;
   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] model[$];
   logic [7:0] exp_dout = '0;
   logic       exp_valid = 1'b0;
   logic       exp_ovf = 1'b0;
   logic       exp_unf = 1'b0;
   logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic       af_h [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic       full_h [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   sync_fifo_flags #(.WIDTH(8), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
      .clk(clk), .reset_n(reset_n), .w_en(w_en), .din(din), .r_en(r_en),
      .dout(dout), .valid(valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic we, input logic re, input logic [7:0] d);
      logic wa, ra;
      logic [7:0] p;
      p = '0;
      w_en = we;
      r_en = re;
      din = d;
      wa = we && model.size() < 4;
      ra = re && model.size() > 0;
      @(posedge clk);
      #1;
      if (ra) p = model.pop_front();
      if (wa) model.push_back(d);
      exp_ovf = we && !wa;
      exp_unf = re && !ra;
`ifdef SYNC_FIFO_FWFT_EN
      exp_valid = model.size() > 0;
      if (exp_valid) exp_dout = model[0];
`else
      exp_valid = ra;
      if (ra) exp_dout = p;
`endif
      w_en = 1'b0;
      r_en = 1'b0;
   endtask

   task automatic do_reset(input int n, input logic we, input logic re);
      reset_n = 1'b0;
      w_en = we;
      r_en = re;
      din = 8'hEE;
      repeat (n) @(posedge clk);
      #1;
      reset_n = 1'b1;
      w_en = 1'b0;
      r_en = 1'b0;
      model.delete();
      exp_dout = '0;
      exp_valid = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".count"}, count, model.size());
      check({tag, ".full"}, full, model.size() == 4);
      check({tag, ".empty"}, empty, model.size() == 0);
      check({tag, ".afull"}, almost_full, model.size() >= 3);
      check({tag, ".aempty"}, almost_empty, model.size() <= 1);
      check({tag, ".ovf"}, overflow, exp_ovf);
      check({tag, ".unf"}, underflow, exp_unf);
      check({tag, ".valid"}, valid, exp_valid);
`ifdef SYNC_FIFO_FWFT_EN
      if (exp_valid) check({tag, ".dout"}, dout, exp_dout);
`else
      check({tag, ".dout"}, dout, exp_dout);
`endif
   endtask

   initial begin
      do_reset(2, 1'b1, 1'b1);
      check_all("rst");
      check("rst.count_h", count, 0);
      check("rst.empty_h", empty, 1);
      check("rst.aempty_h", almost_empty, 1);
      check("rst.valid_h", valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
      check("rst.dout_h", dout, 8'h00);
`endif
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, vals[i]);
         check_all($sformatf("wr%0d", i));
         check($sformatf("wr%0d.count_h", i), count, i + 1);
         check($sformatf("wr%0d.afull_h", i), almost_full, af_h[i]);
         check($sformatf("wr%0d.full_h", i), full, full_h[i]);
      end
      cycle(1'b1, 1'b0, 8'h55);
      check_all("ovf");
      check("ovf.pulse_h", overflow, 1);
      check("ovf.count_h", count, 4);
      cycle(1'b0, 1'b0, 8'h00);
      check_all("ovf_end");
      check("ovf_end.pulse_h", overflow, 0);
`ifdef SYNC_FIFO_FWFT_EN
      check("fwft.head_h", dout, 8'h11);
      check("fwft.valid_h", valid, 1);
`endif
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 8'h00);
         check_all($sformatf("rd%0d", i));
         check($sformatf("rd%0d.count_h", i), count, 3 - i);
`ifndef SYNC_FIFO_FWFT_EN
         check($sformatf("rd%0d.dout_h", i), dout, vals[i]);
         check($sformatf("rd%0d.valid_h", i), valid, 1);
`else
         if (i < 3) check($sformatf("rd%0d.dout_h", i), dout, vals[i + 1]);
`endif
      end
      cycle(1'b0, 1'b1, 8'h00);
      check_all("unf");
      check("unf.pulse_h", underflow, 1);
      check("unf.empty_h", empty, 1);
      cycle(1'b0, 1'b0, 8'h00);
      check_all("unf_end");
      check("unf_end.pulse_h", underflow, 0);
      cycle(1'b1, 1'b0, 8'h01);
      cycle(1'b1, 1'b0, 8'h02);
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, 1'b1, 8'hA0 + 8'(k));
         check_all($sformatf("wrap%0d", k));
         check($sformatf("wrap%0d.count_h", k), count, 2);
`ifndef SYNC_FIFO_FWFT_EN
         check($sformatf("wrap%0d.dout_h", k), dout, k == 0 ? 8'h01 : k == 1 ? 8'h02 : 8'hA0 + 8'(k - 2));
`endif
      end
      cycle(1'b0, 1'b1, 8'h00);
      check_all("drain0");
      cycle(1'b0, 1'b1, 8'h00);
      check_all("drain1");
`ifndef SYNC_FIFO_FWFT_EN
      check("drain1.dout_h", dout, 8'hA9);
`endif
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hC0 + 8'(i));
      cycle(1'b1, 1'b1, 8'h99);
      check_all("both_full");
      check("both_full.count_h", count, 3);
      check("both_full.ovf_h", overflow, 1);
`ifndef SYNC_FIFO_FWFT_EN
      check("both_full.dout_h", dout, 8'hC0);
`endif
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
      check_all("drained");
      cycle(1'b1, 1'b1, 8'h77);
      check_all("both_empty");
      check("both_empty.count_h", count, 1);
      check("both_empty.unf_h", underflow, 1);
      cycle(1'b0, 1'b1, 8'h00);
      check_all("both_empty_rd");
`ifndef SYNC_FIFO_FWFT_EN
      check("both_empty_rd.dout_h", dout, 8'h77);
`endif
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'hD0 + 8'(i));
      check("mid.count_h", count, 3);
      do_reset(1, 1'b0, 1'b0);
      check_all("mid_rst");
      check("mid_rst.count_h", count, 0);
      check("mid_rst.empty_h", empty, 1);
      cycle(1'b1, 1'b0, 8'h5A);
      check_all("post_wr");
`ifdef SYNC_FIFO_FWFT_EN
      check("post_wr.dout_h", dout, 8'h5A);
`endif
      cycle(1'b0, 1'b1, 8'h00);
      check_all("post_rd");
`ifndef SYNC_FIFO_FWFT_EN
      check("post_rd.dout_h", dout, 8'h5A);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
